// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : ID-side operands/control, forward sources and EX-side outputs
//               of the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
  parameter int W = 32
);
  logic         id_valid;
  logic [W-1:0] id_rs_data;
  logic [W-1:0] id_rt_data;
  logic [W-1:0] id_imm;
  logic [4:0]   id_rs;
  logic [4:0]   id_rt;
  logic [4:0]   id_rd;
  logic         id_alu_src;
  logic [3:0]   id_alu_control;
  logic         id_reg_write;
  logic         id_mem_read;
  logic         id_mem_write;
  logic         id_mem_to_reg;
  logic         stall;
  logic         flush;
  logic         exmem_reg_write;
  logic [4:0]   exmem_rd;
  logic [W-1:0] exmem_result;
  logic         memwb_reg_write;
  logic [4:0]   memwb_rd;
  logic [W-1:0] memwb_result;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_control;
  logic [W-1:0] ex_store_data;
  logic         ex_valid;
  logic         ex_reg_write;
  logic         ex_mem_read;
  logic         ex_mem_write;
  logic         ex_mem_to_reg;
  logic [4:0]   ex_rd;
  logic         load_use_hazard;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alu_src, id_alu_control, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, stall, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  alu_a, alu_b, alu_control, ex_store_data, ex_valid, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_rd, load_use_hazard
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alu_src, id_alu_control, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, stall, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output alu_a, alu_b, alu_control, ex_store_data, ex_valid, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_rd, load_use_hazard
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use bubble insertion and
//               EX/MEM, MEM/WB operand forwarding into the ALU inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int W = 32
) (
  input  wire logic     clk,
  input  wire logic     reset,
  id_ex_stage_if.slave  bus
);
  localparam logic [3:0] c_alu_add = 4'b0010;

  logic         r_valid;
  logic [W-1:0] r_rs_data;
  logic [W-1:0] r_rt_data;
  logic [W-1:0] r_imm;
  logic [4:0]   r_rs;
  logic [4:0]   r_rt;
  logic [4:0]   r_rd;
  logic         r_alu_src;
  logic [3:0]   r_alu_control;
  logic         r_reg_write;
  logic         r_mem_read;
  logic         r_mem_write;
  logic         r_mem_to_reg;

  logic         w_hazard;
  logic         w_wb_hit_rs;
  logic         w_wb_hit_rt;
  logic [W-1:0] w_fa;
  logic [W-1:0] w_fb;

  // The consumer needs rt as a register when it is an ALU operand or store data.
  assign w_hazard = r_valid & r_mem_read & bus.id_valid & (r_rd != 5'd0) &
                    ((r_rd == bus.id_rs) |
                     ((r_rd == bus.id_rt) & ~bus.id_alu_src) |
                     ((r_rd == bus.id_rt) & bus.id_mem_write));

  // WB writes the register file on the same edge ID reads it; grab the new value.
  assign w_wb_hit_rs = bus.memwb_reg_write & (bus.memwb_rd != 5'd0) &
                       (bus.memwb_rd == bus.id_rs);
  assign w_wb_hit_rt = bus.memwb_reg_write & (bus.memwb_rd != 5'd0) &
                       (bus.memwb_rd == bus.id_rt);

  always_ff @(posedge clk) begin
    if (reset || bus.flush || (!bus.stall && w_hazard)) begin
      r_valid       <= 1'b0;
      r_rs_data     <= '0;
      r_rt_data     <= '0;
      r_imm         <= '0;
      r_rs          <= 5'd0;
      r_rt          <= 5'd0;
      r_rd          <= 5'd0;
      r_alu_src     <= 1'b0;
      r_alu_control <= c_alu_add;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
    end else if (!bus.stall) begin
      r_valid       <= bus.id_valid;
      r_rs_data     <= w_wb_hit_rs ? bus.memwb_result : bus.id_rs_data;
      r_rt_data     <= w_wb_hit_rt ? bus.memwb_result : bus.id_rt_data;
      r_imm         <= bus.id_imm;
      r_rs          <= bus.id_rs;
      r_rt          <= bus.id_rt;
      r_rd          <= bus.id_rd;
      r_alu_src     <= bus.id_alu_src;
      r_alu_control <= bus.id_alu_control;
      r_reg_write   <= bus.id_reg_write;
      r_mem_read    <= bus.id_mem_read;
      r_mem_write   <= bus.id_mem_write;
      r_mem_to_reg  <= bus.id_mem_to_reg;
    end
  end

  // EX/MEM holds the younger result, so it takes precedence over MEM/WB.
  always_comb begin
    w_fa = r_rs_data;
    if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == r_rs))
      w_fa = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == r_rs))
      w_fa = bus.memwb_result;
  end

  always_comb begin
    w_fb = r_rt_data;
    if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == r_rt))
      w_fb = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == r_rt))
      w_fb = bus.memwb_result;
  end

  assign bus.alu_a           = w_fa;
  assign bus.alu_b           = r_alu_src ? r_imm : w_fb;
  assign bus.ex_store_data   = w_fb;
  assign bus.alu_control     = r_alu_control;
  assign bus.ex_valid        = r_valid;
  assign bus.ex_reg_write    = r_reg_write;
  assign bus.ex_mem_read     = r_mem_read;
  assign bus.ex_mem_write    = r_mem_write;
  assign bus.ex_mem_to_reg   = r_mem_to_reg;
  assign bus.ex_rd           = r_rd;
  assign bus.load_use_hazard = w_hazard;
endmodule
`default_nettype wire
